// File: rtl/comb_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comb_pack_pkg
// Brief    : Shared constants and types for the combination_pack slice.
//            A word is split into 16-bit units; real elements occupy one
//            unit and complex elements occupy two.
// Revision : 1.0 - initial release
// ============================================================================
package comb_pack_pkg;

    localparam int UNITS_PER_WORD = 8;
    localparam int UNIT_W         = 16;

    typedef enum logic {
        MODE_COMPLEX = 1'b0,
        MODE_REAL    = 1'b1
    } mode_e;

    typedef logic [UNIT_W-1:0] unit_t;

endpackage : comb_pack_pkg
`default_nettype wire

// File: rtl/comb_lane_compact.sv
`default_nettype none
// ============================================================================
// Module   : comb_lane_compact
// Brief    : Stage 1. Moves the kept elements of one word down to the lowest
//            units (order preserved) and registers the word together with
//            its kept-unit and kept-element counts.
// Revision : 1.0 - initial release
// ============================================================================
module comb_lane_compact
    import comb_pack_pkg::*;
#(
    parameter int NUM        = UNITS_PER_WORD,
    parameter int DATA_WIDTH = UNIT_W,
    parameter int K_WIDTH    = $clog2(NUM + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_switch,
    input  logic [NUM*DATA_WIDTH-1:0] i_data,
    input  logic [NUM-1:0]            i_keep,
    input  logic                      i_valid,
    input  logic                      i_last,
    output logic [NUM*DATA_WIDTH-1:0] o_data,
    output logic [K_WIDTH-1:0]        o_k,
    output logic [K_WIDTH-1:0]        o_nelem,
    output logic                      o_valid,
    output logic                      o_last
);

    mode_e                      w_mode;
    logic [NUM-1:0]             w_ukeep;
    logic [NUM*DATA_WIDTH-1:0]  w_data;
    logic [K_WIDTH-1:0]         w_cnt;
    logic [K_WIDTH-1:0]         w_nelem;

    assign w_mode = mode_e'(i_switch);

    // A complex element spans two units, so both units inherit its keep flag;
    // the upper keep bits are never consulted in complex mode.
    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_ukeep
            assign w_ukeep[gi] = (w_mode == MODE_REAL) ? i_keep[gi] : i_keep[gi/2];
        end
    endgenerate

    // Prefix-sum compaction: each kept unit lands at the count of kept units below it.
    always_comb begin
        w_data = '0;
        w_cnt  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (w_ukeep[i]) begin
                w_data[int'(w_cnt)*DATA_WIDTH +: DATA_WIDTH] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_cnt = w_cnt + K_WIDTH'(1);
            end
        end
        w_nelem = (w_mode == MODE_REAL) ? w_cnt : (w_cnt >> 1);
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_k     <= '0;
            o_nelem <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            o_valid <= i_valid;
            o_last  <= i_valid & i_last;
            if (i_valid) begin
                o_data  <= w_data;
                o_k     <= w_cnt;
                o_nelem <= w_nelem;
            end
        end
    end

endmodule : comb_lane_compact
`default_nettype wire

// File: rtl/combination_pack.sv
`default_nettype none
// ============================================================================
// Module   : combination_pack
// Brief    : Packs kept elements of lane-masked words into dense words,
//            flushes a zero-padded partial word at frame end and reports the
//            kept-element count of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module combination_pack
    import comb_pack_pkg::*;
#(
    parameter int READ_RAM_WIDTH = 128,
    parameter int NUM            = UNITS_PER_WORD,
    parameter int DATA_WIDTH     = UNIT_W,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_switch,
    input  logic [READ_RAM_WIDTH-1:0] i_x0,
    input  logic [NUM-1:0]            i_keep,
    input  logic                      i_x0_valid,
    input  logic                      i_last,
    output logic [READ_RAM_WIDTH-1:0] o_y0,
    output logic                      o_y0_valid,
    output logic                      o_y0_last,
    output logic [CNT_WIDTH-1:0]      o_cnt,
    output logic                      o_ovf
);

    localparam int c_KW = $clog2(NUM + 1);
    localparam int c_RW = $clog2(NUM);
    localparam int c_SW = c_RW + 1;
    localparam int c_W  = READ_RAM_WIDTH;

    logic [c_W-1:0]        s1_data;
    logic [c_KW-1:0]       s1_k;
    logic [c_KW-1:0]       s1_nelem;
    logic                  s1_valid;
    logic                  s1_last;

    logic [c_W-1:0]        r_res;
    logic [c_RW-1:0]       r_r;
    logic [c_W-1:0]        r_pend;
    logic                  r_pend_v;
    logic [CNT_WIDTH-1:0]  r_pend_cnt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_post_last;

    logic [2*c_W-1:0]      w_merge;
    logic [c_SW-1:0]       w_sum;
    logic                  w_full;
    logic                  w_rem;
    logic [CNT_WIDTH-1:0]  w_total;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [c_KW-1:0]      b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    comb_lane_compact #(
        .NUM        (NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .K_WIDTH    (c_KW)
    ) u_compact (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_switch(i_switch),
        .i_data  (i_x0),
        .i_keep  (i_keep),
        .i_valid (i_x0_valid),
        .i_last  (i_last),
        .o_data  (s1_data),
        .o_k     (s1_k),
        .o_nelem (s1_nelem),
        .o_valid (s1_valid),
        .o_last  (s1_last)
    );

    // Two-word merge window: compacted units appended directly above the residual.
    // Units above r+k are zero, so a partial word is already zero-padded.
    always_comb begin
        w_merge = {{c_W{1'b0}}, r_res} | ({{c_W{1'b0}}, s1_data} << (int'(r_r) * DATA_WIDTH));
        w_sum   = c_SW'(r_r) + c_SW'(s1_k);
        w_full  = (w_sum >= c_SW'(NUM));
        w_rem   = (w_sum[c_RW-1:0] != '0);
        w_total = sat_add(r_cnt, s1_nelem);
    end

    // Stage 2: residual/pending bookkeeping and the registered output stream.
    // A pending flush owns the output; a word arriving alongside it is still
    // absorbed into the residual but cannot emit that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_y0       <= '0;
            o_y0_valid <= 1'b0;
            o_y0_last  <= 1'b0;
            o_cnt      <= '0;
            r_res      <= '0;
            r_r        <= '0;
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_pend_cnt <= '0;
            r_cnt      <= '0;
        end else begin
            o_y0_valid <= 1'b0;
            o_y0_last  <= 1'b0;
            if (r_pend_v) begin
                o_y0       <= r_pend;
                o_y0_valid <= 1'b1;
                o_y0_last  <= 1'b1;
                o_cnt      <= r_pend_cnt;
                r_pend_v   <= 1'b0;
            end
            if (s1_valid) begin
                if (s1_last) begin
                    r_res <= '0;
                    r_r   <= '0;
                    r_cnt <= '0;
                    if (w_full && w_rem) begin
                        // Full word now, zero-padded remainder next cycle with last.
                        if (!r_pend_v) begin
                            o_y0       <= w_merge[c_W-1:0];
                            o_y0_valid <= 1'b1;
                        end
                        r_pend     <= w_merge[2*c_W-1:c_W];
                        r_pend_v   <= 1'b1;
                        r_pend_cnt <= w_total;
                    end else if (!r_pend_v) begin
                        // Exact full word, partial word, or all-zero word for an empty tail.
                        o_y0       <= w_merge[c_W-1:0];
                        o_y0_valid <= 1'b1;
                        o_y0_last  <= 1'b1;
                        o_cnt      <= w_total;
                    end
                end else begin
                    r_cnt <= w_total;
                    r_r   <= w_sum[c_RW-1:0];
                    if (w_full) begin
                        if (!r_pend_v) begin
                            o_y0       <= w_merge[c_W-1:0];
                            o_y0_valid <= 1'b1;
                        end
                        r_res <= w_merge[2*c_W-1:c_W];
                    end else begin
                        r_res <= w_merge[c_W-1:0];
                    end
                end
            end
        end
    end

    // Sticky flag: a word reaching stage 2 right after a frame end broke the idle-cycle rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post_last <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            r_post_last <= s1_valid & s1_last;
            if (r_post_last && s1_valid) begin
                o_ovf <= 1'b1;
            end
        end
    end

endmodule : combination_pack
`default_nettype wire

// File: tb/tb_combination_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_combination_pack
// Brief    : Directed self-checking bench for combination_pack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combination_pack;

    logic         clk;
    logic         rst_n;
    logic         i_switch;
    logic [127:0] i_x0;
    logic [7:0]   i_keep;
    logic         i_x0_valid;
    logic         i_last;
    logic [127:0] o_y0;
    logic         o_y0_valid;
    logic         o_y0_last;
    logic [15:0]  o_cnt;
    logic         o_ovf;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [127:0] q_data[$];
    logic         q_last[$];
    logic [15:0]  q_cnt[$];
    int           q_cyc[$];

    combination_pack u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_switch  (i_switch),
        .i_x0      (i_x0),
        .i_keep    (i_keep),
        .i_x0_valid(i_x0_valid),
        .i_last    (i_last),
        .o_y0      (o_y0),
        .o_y0_valid(o_y0_valid),
        .o_y0_last (o_y0_last),
        .o_cnt     (o_cnt),
        .o_ovf     (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture the output stream away from the active edge.
    always @(negedge clk) begin
        if (o_y0_valid) begin
            q_data.push_back(o_y0);
            q_last.push_back(o_y0_last);
            q_cnt.push_back(o_cnt);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Lane i of the word carries {tag, i}.
    function automatic logic [127:0] mkword(input logic [7:0] tag);
        logic [127:0] w;
        for (int i = 0; i < 8; i++) w[i*16 +: 16] = {tag, 8'(i)};
        return w;
    endfunction

    task automatic drive(input logic sw, input logic [127:0] x, input logic [7:0] k,
                         input logic last, output int c);
        @(posedge clk); #1;
        i_switch   = sw;
        i_x0       = x;
        i_keep     = k;
        i_x0_valid = 1'b1;
        i_last     = last;
        c          = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            i_x0_valid = 1'b0;
            i_last     = 1'b0;
            i_keep     = 8'h00;
        end
    endtask

    task automatic qclear();
        q_data.delete(); q_last.delete(); q_cnt.delete(); q_cyc.delete();
    endtask

    logic [127:0] wa, wb, wc;
    int c0, c1, c2;

    initial begin
        rst_n = 1'b0; i_switch = 1'b1; i_x0 = '0; i_keep = '0; i_x0_valid = 1'b0; i_last = 1'b0;
        wa = mkword(8'hA0); wb = mkword(8'hB0); wc = mkword(8'hC0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_y0",    o_y0, 128'h0);
        check("rst_valid", 128'(o_y0_valid), 128'h0);
        check("rst_last",  128'(o_y0_last), 128'h0);
        check("rst_cnt",   128'(o_cnt), 128'h0);
        check("rst_ovf",   128'(o_ovf), 128'h0);
        rst_n = 1'b1;
        idle(2);

        // Real, all kept, 3 words: pass-through at t+2.
        qclear();
        drive(1'b1, wa, 8'hFF, 1'b0, c0);
        drive(1'b1, wb, 8'hFF, 1'b0, c1);
        drive(1'b1, wc, 8'hFF, 1'b1, c2);
        idle(6);
        check("t1_n", 128'(q_data.size()), 128'd3);
        if (q_data.size() == 3) begin
            check("t1_d0", q_data[0], wa);
            check("t1_d1", q_data[1], wb);
            check("t1_d2", q_data[2], wc);
            check("t1_lat", 128'(q_cyc[0]), 128'(c0 + 2));
            check("t1_l0", 128'(q_last[0]), 128'h0);
            check("t1_l2", 128'(q_last[2]), 128'h1);
            check("t1_cnt", 128'(q_cnt[2]), 128'd24);
        end

        // Real, low four lanes of two words merge into one.
        qclear();
        drive(1'b1, wa, 8'h0F, 1'b0, c0);
        drive(1'b1, wb, 8'h0F, 1'b1, c1);
        idle(6);
        check("t2_n", 128'(q_data.size()), 128'd1);
        if (q_data.size() == 1) begin
            check("t2_d", q_data[0], {wb[63:0], wa[63:0]});
            check("t2_l", 128'(q_last[0]), 128'h1);
            check("t2_cnt", 128'(q_cnt[0]), 128'd8);
            check("t2_lat", 128'(q_cyc[0]), 128'(c1 + 2));
        end

        // Real, 7 + 7 units: full word then split remainder with last.
        qclear();
        drive(1'b1, wa, 8'h7F, 1'b0, c0);
        drive(1'b1, wb, 8'h7F, 1'b1, c1);
        idle(6);
        check("t3_n", 128'(q_data.size()), 128'd2);
        if (q_data.size() == 2) begin
            check("t3_d0", q_data[0], {wb[15:0], wa[111:0]});
            check("t3_l0", 128'(q_last[0]), 128'h0);
            check("t3_lat0", 128'(q_cyc[0]), 128'(c1 + 2));
            check("t3_d1", q_data[1], {32'h0, wb[111:16]});
            check("t3_l1", 128'(q_last[1]), 128'h1);
            check("t3_lat1", 128'(q_cyc[1]), 128'(c1 + 3));
            check("t3_cnt", 128'(q_cnt[1]), 128'd14);
        end

        // Complex, elements 0 and 2 kept; upper keep bits are noise.
        qclear();
        drive(1'b0, wc, 8'hA5, 1'b1, c0);
        idle(6);
        check("t4_n", 128'(q_data.size()), 128'd1);
        if (q_data.size() == 1) begin
            check("t4_d", q_data[0], {64'h0, wc[95:64], wc[31:0]});
            check("t4_l", 128'(q_last[0]), 128'h1);
            check("t4_cnt", 128'(q_cnt[0]), 128'd2);
        end

        // Empty frame, then a word in the mandatory idle cycle.
        qclear();
        check("t5_ovf0", 128'(o_ovf), 128'h0);
        drive(1'b1, wa, 8'h00, 1'b0, c0);
        drive(1'b1, wb, 8'h00, 1'b1, c1);
        drive(1'b1, wc, 8'h00, 1'b0, c2);
        idle(6);
        check("t5_n", 128'(q_data.size()), 128'd1);
        if (q_data.size() == 1) begin
            check("t5_d", q_data[0], 128'h0);
            check("t5_l", 128'(q_last[0]), 128'h1);
            check("t5_cnt", 128'(q_cnt[0]), 128'd0);
        end
        check("t5_ovf1", 128'(o_ovf), 128'h1);
        idle(5);
        check("t5_ovf2", 128'(o_ovf), 128'h1);

        // Build r=5 after a real output, then reset mid-frame.
        drive(1'b1, wa, 8'hFF, 1'b0, c0);
        drive(1'b1, wb, 8'h1F, 1'b0, c1);
        idle(3);
        check("t6_pre_y0", o_y0, wa);
        rst_n = 1'b0;
        #1;
        check("t6_rst_y0",    o_y0, 128'h0);
        check("t6_rst_valid", 128'(o_y0_valid), 128'h0);
        check("t6_rst_ovf",   128'(o_ovf), 128'h0);
        check("t6_rst_cnt",   128'(o_cnt), 128'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        qclear();
        drive(1'b1, wc, 8'hFF, 1'b1, c0);
        idle(6);
        check("t6_n", 128'(q_data.size()), 128'd1);
        if (q_data.size() == 1) begin
            check("t6_d", q_data[0], wc);
            check("t6_l", 128'(q_last[0]), 128'h1);
            check("t6_cnt", 128'(q_cnt[0]), 128'd8);
            check("t6_lat", 128'(q_cyc[0]), 128'(c0 + 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_combination_pack
`default_nettype wire
